// File: rtl/id_dispatch_buffer_if.sv
// Decoder-side and dispatch-side handshake bundle for id_dispatch_buffer.
// The buffer uses the slave view; the producer/consumer side uses master.
interface id_dispatch_buffer_if;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic [2:0]  in_fu;
  logic        in_ready;
  logic        alu_ready;
  logic        mult_ready;
  logic        lsq_ready;
  logic        br_ready;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [2:0]  out_fu;
  logic        out_illegal;
  logic        out_fire;

  modport slave (
    input  in_valid, in_inst, in_pc, in_fu,
    input  alu_ready, mult_ready, lsq_ready, br_ready,
    output in_ready,
    output out_valid, out_inst, out_pc, out_fu, out_illegal, out_fire
  );

  modport master (
    output in_valid, in_inst, in_pc, in_fu,
    output alu_ready, mult_ready, lsq_ready, br_ready,
    input  in_ready,
    input  out_valid, out_inst, out_pc, out_fu, out_illegal, out_fire
  );
endinterface

// File: rtl/id_dispatch_buffer.sv
// In-order decode-to-dispatch FIFO, steered by FU class, with squash and stall counter.
// Optional DISPATCH_BYPASS_EN: zero-latency pass-through when the buffer is empty.
module id_dispatch_buffer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     squash,
  id_dispatch_buffer_if.slave      dif,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         stall_cycles
);

  // Handshake: an instruction moves in when in_valid && in_ready (in_ready from
  // registered occupancy only), and out when out_valid && class-ready, i.e. out_fire.
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = DEPTH[PTR_W:0];
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [DEPTH-1:0] vld_q, vld_d;

  logic [31:0]      inst_mem [DEPTH];
  logic [31:0]      pc_mem   [DEPTH];
  logic [2:0]       fu_mem   [DEPTH];
  logic [DEPTH-1:0] ill_mem;

  logic       in_ill;
  logic [2:0] in_fu_n;
  logic       head_valid, head_sel, bypass, enq, deq;

  function automatic logic class_ready(input logic [2:0] fu, input logic alu,
                                       input logic mult, input logic lsq, input logic br);
    case (fu)
      3'b001:  return alu;
      3'b010:  return mult;
      3'b011:  return lsq;
      default: return br;
    endcase
  endfunction

  always_comb begin
    in_ill  = !(dif.in_fu inside {3'b001, 3'b010, 3'b011, 3'b100});
    in_fu_n = in_ill ? 3'b100 : dif.in_fu;
  end

  assign head_valid   = (count_q != '0);
  assign head_sel     = class_ready(fu_mem[head_q], dif.alu_ready, dif.mult_ready,
                                    dif.lsq_ready, dif.br_ready);
  assign dif.in_ready = (count_q != FULL_CNT);

`ifdef DISPATCH_BYPASS_EN
  assign bypass = (count_q == '0) && dif.in_valid && !squash &&
                  class_ready(in_fu_n, dif.alu_ready, dif.mult_ready,
                              dif.lsq_ready, dif.br_ready);
`else
  assign bypass = 1'b0;
`endif

  assign enq = dif.in_valid && dif.in_ready && !squash && !bypass;
  assign deq = head_valid && head_sel && !squash;

  always_comb begin
    dif.out_valid   = 1'b0;
    dif.out_inst    = '0;
    dif.out_pc      = '0;
    dif.out_fu      = '0;
    dif.out_illegal = 1'b0;
    dif.out_fire    = 1'b0;
    if (bypass) begin
      dif.out_valid   = 1'b1;
      dif.out_inst    = dif.in_inst;
      dif.out_pc      = dif.in_pc;
      dif.out_fu      = in_fu_n;
      dif.out_illegal = in_ill;
      dif.out_fire    = 1'b1;
    end else if (head_valid) begin
      dif.out_valid   = 1'b1;
      dif.out_inst    = inst_mem[head_q];
      dif.out_pc      = pc_mem[head_q];
      dif.out_fu      = fu_mem[head_q];
      dif.out_illegal = ill_mem[head_q];
      dif.out_fire    = deq;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    vld_d   = vld_q;
    stall_d = stall_q;
    if (squash) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      vld_d   = '0;
    end else begin
      if (enq) begin
        tail_d         = tail_q + PTR_ONE;
        vld_d[tail_q]  = 1'b1;
      end
      if (deq) begin
        head_d         = head_q + PTR_ONE;
        vld_d[head_q]  = 1'b0;
      end
      if (enq && !deq)      count_d = count_q + CNT_ONE;
      else if (deq && !enq) count_d = count_q - CNT_ONE;
    end
    // Saturates rather than wraps so long stalls stay visible.
    if (dif.out_valid && !dif.out_fire && !squash && (stall_q != '1))
      stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      stall_q <= '0;
      vld_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      stall_q <= stall_d;
      vld_q   <= vld_d;
    end
  end

  // Payload storage needs no reset: it is only observed behind count_q != 0.
  always_ff @(posedge clock) begin
    if (enq) begin
      inst_mem[tail_q] <= dif.in_inst;
      pc_mem[tail_q]   <= dif.in_pc;
      fu_mem[tail_q]   <= in_fu_n;
      ill_mem[tail_q]  <= in_ill;
    end
  end

  assign count        = count_q;
  assign stall_cycles = stall_q;

endmodule
